// File: rtl/rvv_xrf_wb_pkg.sv
// Shared types and defaults for the scalar-regfile write-back arbiter.
//   NUM_RT_UOP  : number of retire write-back slots in the vector backend
//   XRF_*       : default widths / depth used by the arbiter and its interface
//   xrf_wb_t    : one scalar write-back entry {addr, data}
// Optional feature macro RVV_XRF_WB_X0_FILTER_EN is consumed by the compactor.
package rvv_xrf_wb_pkg;
  localparam int NUM_RT_UOP = 2;
  localparam int XRF_DEPTH  = 4;
  localparam int XRF_ADDR_W = 5;
  localparam int XRF_DATA_W = 32;

  typedef struct packed {
    logic [XRF_ADDR_W-1:0] addr;
    logic [XRF_DATA_W-1:0] data;
  } xrf_wb_t;
endpackage

// File: rtl/rvv_xrf_wb_if.sv
// Handshake bundle between the retire write-back slots, the arbiter and the
// async scalar-regfile write-back sink.
//   rt_valid_i/addr_i/data_i : per-slot write-back request (backend -> arbiter)
//   rt_ready_o               : per-slot accept (arbiter -> backend)
//   async_rd_valid/addr/data : head of write-back queue (arbiter -> sink)
//   async_rd_ready           : sink accepts head (sink -> arbiter)
// Modports: slave = arbiter side, master = backend/sink environment side.
interface rvv_xrf_wb_if
  import rvv_xrf_wb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_RT_UOP,
  parameter int ADDR_W    = XRF_ADDR_W,
  parameter int DATA_W    = XRF_DATA_W
);
  logic [NUM_PORTS-1:0]             rt_valid_i;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rt_addr_i;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rt_data_i;
  logic [NUM_PORTS-1:0]             rt_ready_o;
  logic                             async_rd_valid;
  logic [ADDR_W-1:0]                async_rd_addr;
  logic [DATA_W-1:0]                async_rd_data;
  logic                             async_rd_ready;

  modport slave (
    input  rt_valid_i, rt_addr_i, rt_data_i, async_rd_ready,
    output rt_ready_o, async_rd_valid, async_rd_addr, async_rd_data
  );

  modport master (
    output rt_valid_i, rt_addr_i, rt_data_i, async_rd_ready,
    input  rt_ready_o, async_rd_valid, async_rd_addr, async_rd_data
  );
endinterface

// File: rtl/rvv_xrf_wb_compactor.sv
// Combinational compactor: packs accepted retire slots (valid & ready) into
// consecutive push lanes in ascending slot order and reports how many lanes
// are used. Gaps between valid slots are squeezed out.
//   valid/ready : per-slot handshake
//   addr/data   : per-slot payload
//   push_addr/data : compacted payload, lanes [0 .. push_cnt-1] meaningful
//   push_cnt    : number of entries to enqueue this cycle
// With RVV_XRF_WB_X0_FILTER_EN defined, accepted writes to x0 are dropped
// here (handshake still completes upstream, nothing is enqueued).
module rvv_xrf_wb_compactor #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = $clog2(NUM_PORTS+1)
) (
  input  logic [NUM_PORTS-1:0]             valid,
  input  logic [NUM_PORTS-1:0]             ready,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] data,
  output logic [NUM_PORTS-1:0][ADDR_W-1:0] push_addr,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] push_data,
  output logic [CNT_W-1:0]                 push_cnt
);
  logic [NUM_PORTS-1:0] take;

`ifdef RVV_XRF_WB_X0_FILTER_EN
  logic [NUM_PORTS-1:0] is_x0;
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_x0
    assign is_x0[g] = (addr[g] == '0);
  end
  assign take = valid & ready & ~is_x0;
`else
  assign take = valid & ready;
`endif

  // Running index walks slots in order; each taken slot lands on the lane
  // equal to the number of taken slots below it.
  always_comb begin
    logic [CNT_W-1:0] idx;
    push_addr = '0;
    push_data = '0;
    idx       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (take[i]) begin
        for (int o = 0; o < NUM_PORTS; o++) begin
          if (idx == CNT_W'(o)) begin
            push_addr[o] = addr[i];
            push_data[o] = data[i];
          end
        end
        idx = idx + CNT_W'(1);
      end
    end
    push_cnt = idx;
  end
endmodule

// File: rtl/rvv_xrf_wb_arbiter.sv
// Merges NUM_PORTS retire scalar write-back slots into the single async
// scalar-regfile write-back channel through an in-order FIFO of DEPTH entries.
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : retire slots in, rt_ready_o out, async_rd_* channel
//   fill_level_o : occupied FIFO entries
// Slot readiness is derived from the registered count only, so async_rd_ready
// never reaches rt_ready_o combinationally. No bypass: an entry is visible at
// the output no earlier than the cycle after it is accepted.
// Optional macro RVV_XRF_WB_X0_FILTER_EN (see compactor) drops x0 writes.
module rvv_xrf_wb_arbiter
  import rvv_xrf_wb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_RT_UOP,
  parameter int DEPTH     = XRF_DEPTH,
  parameter int ADDR_W    = XRF_ADDR_W,
  parameter int DATA_W    = XRF_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  rvv_xrf_wb_if.slave                bus,
  output logic [$clog2(DEPTH+1)-1:0] fill_level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int KW = $clog2(NUM_PORTS+1);

  logic [DEPTH-1:0][ADDR_W-1:0]     mem_addr;
  logic [DEPTH-1:0][DATA_W-1:0]     mem_data;
  logic [PW-1:0]                    wr_ptr, rd_ptr;
  logic [CW-1:0]                    count, free;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] push_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] push_data;
  logic [KW-1:0]                    push_cnt;
  logic                             pop;

  assign free = CW'(DEPTH) - count;

  // Prefix-shaped ready: slot i gets in only if i+1 entries are free.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rdy
    assign bus.rt_ready_o[g] = (free > CW'(g));
  end

  rvv_xrf_wb_compactor #(
    .NUM_PORTS (NUM_PORTS),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CNT_W     (KW)
  ) u_compactor (
    .valid     (bus.rt_valid_i),
    .ready     (bus.rt_ready_o),
    .addr      (bus.rt_addr_i),
    .data      (bus.rt_data_i),
    .push_addr (push_addr),
    .push_data (push_data),
    .push_cnt  (push_cnt)
  );

  assign bus.async_rd_valid = (count != '0);
  assign bus.async_rd_addr  = mem_addr[rd_ptr];
  assign bus.async_rd_data  = mem_data[rd_ptr];
  assign pop                = bus.async_rd_valid & bus.async_rd_ready;
  assign fill_level_o       = count;

  // Storage is not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (KW'(k) < push_cnt) begin
        mem_addr[wr_ptr + PW'(k)] <= push_addr[k];
        mem_data[wr_ptr + PW'(k)] <= push_data[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push_cnt) - CW'(pop);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (CW'(push_cnt) <= free);
  end
`endif
endmodule

// File: tb/tb_rvv_xrf_wb_arbiter.sv
// Directed bench for rvv_xrf_wb_arbiter: reset state, dual-slot push, full /
// backpressure, partial ready at count=3, pointer wrap, x0 handling and
// mid-operation reset. Inputs change 1 time unit after the rising edge and
// outputs are sampled there too.
module tb_rvv_xrf_wb_arbiter;
  import rvv_xrf_wb_pkg::*;

  localparam int NP = 2;
  localparam int D  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   fill;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  rvv_xrf_wb_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  rvv_xrf_wb_arbiter #(
    .NUM_PORTS (NP),
    .DEPTH     (D),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .fill_level_o (fill)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int s, input xrf_wb_t e);
    bus.rt_addr_i[s] = e.addr;
    bus.rt_data_i[s] = e.data;
  endtask

  initial begin
    rst                = 1'b1;
    bus.rt_valid_i     = '0;
    bus.rt_addr_i      = '0;
    bus.rt_data_i      = '0;
    bus.async_rd_ready = 1'b0;
    step();
    step();
    chk("rst_ready", 64'(bus.rt_ready_o), 64'h3);
    chk("rst_valid", 64'(bus.async_rd_valid), 64'h0);
    chk("rst_fill", 64'(fill), 64'h0);
    rst = 1'b0;
    step();
    chk("idle_ready", 64'(bus.rt_ready_o), 64'h3);
    chk("idle_valid", 64'(bus.async_rd_valid), 64'h0);

    // dual push, sink ready
    bus.async_rd_ready = 1'b1;
    put(0, '{addr: 5'd5, data: 32'hAAAA_0001});
    put(1, '{addr: 5'd6, data: 32'hBBBB_0002});
    bus.rt_valid_i = 2'b11;
    step();
    bus.rt_valid_i = 2'b00;
    chk("dual_fill0", 64'(fill), 64'd2);
    chk("dual_valid0", 64'(bus.async_rd_valid), 64'h1);
    chk("dual_addr0", 64'(bus.async_rd_addr), 64'd5);
    chk("dual_data0", 64'(bus.async_rd_data), 64'hAAAA_0001);
    step();
    chk("dual_fill1", 64'(fill), 64'd1);
    chk("dual_addr1", 64'(bus.async_rd_addr), 64'd6);
    chk("dual_data1", 64'(bus.async_rd_data), 64'hBBBB_0002);
    step();
    chk("dual_fill2", 64'(fill), 64'd0);
    chk("dual_valid2", 64'(bus.async_rd_valid), 64'h0);

    // fill to full with sink stalled
    bus.async_rd_ready = 1'b0;
    put(0, '{addr: 5'd1, data: 32'h10});
    put(1, '{addr: 5'd2, data: 32'h11});
    bus.rt_valid_i = 2'b11;
    step();
    chk("full_ready_mid", 64'(bus.rt_ready_o), 64'h3);
    put(0, '{addr: 5'd3, data: 32'h12});
    put(1, '{addr: 5'd4, data: 32'h13});
    step();
    bus.rt_valid_i = 2'b00;
    chk("full_fill", 64'(fill), 64'd4);
    chk("full_ready", 64'(bus.rt_ready_o), 64'h0);
    chk("full_head", 64'(bus.async_rd_addr), 64'd1);
    step();
    chk("full_hold_addr", 64'(bus.async_rd_addr), 64'd1);
    chk("full_hold_data", 64'(bus.async_rd_data), 64'h10);
    bus.async_rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_addr%0d", k), 64'(bus.async_rd_addr), 64'(k + 1));
      chk($sformatf("drain_data%0d", k), 64'(bus.async_rd_data), 64'(32'h10 + k));
      step();
    end
    chk("drain_empty", 64'(fill), 64'd0);

    // count=3: only slot0 ready; gap slot1 accepted once count<=2
    bus.async_rd_ready = 1'b0;
    put(0, '{addr: 5'd8, data: 32'h8});
    put(1, '{addr: 5'd9, data: 32'h9});
    bus.rt_valid_i = 2'b11;
    step();
    put(0, '{addr: 5'd10, data: 32'hA});
    bus.rt_valid_i = 2'b01;
    step();
    chk("c3_fill", 64'(fill), 64'd3);
    chk("c3_ready", 64'(bus.rt_ready_o), 64'h1);
    put(0, '{addr: 5'd11, data: 32'hB});
    put(1, '{addr: 5'd12, data: 32'hC});
    bus.rt_valid_i = 2'b11;
    step();
    chk("c3_take0_fill", 64'(fill), 64'd4);
    bus.rt_valid_i = 2'b10;
    bus.async_rd_ready = 1'b1;
    chk("c3_s0_ready", 64'(bus.rt_ready_o), 64'h0);
    step();
    chk("c3_s1_head", 64'(bus.async_rd_addr), 64'd9);
    chk("c3_s1_ready", 64'(bus.rt_ready_o), 64'h1);
    step();
    chk("c3_s2_head", 64'(bus.async_rd_addr), 64'd10);
    chk("c3_s2_ready", 64'(bus.rt_ready_o), 64'h3);
    step();
    bus.rt_valid_i = 2'b00;
    chk("c3_s3_head", 64'(bus.async_rd_addr), 64'd11);
    chk("c3_s3_fill", 64'(fill), 64'd2);
    step();
    chk("c3_s4_head", 64'(bus.async_rd_addr), 64'd12);
    chk("c3_s4_data", 64'(bus.async_rd_data), 64'hC);
    step();
    chk("c3_s5_fill", 64'(fill), 64'd0);

    // wrap-around, single pushes with continuous sink ready
    for (int k = 0; k < 10; k++) begin
      put(0, '{addr: 5'(k + 1), data: 32'(k)});
      bus.rt_valid_i = 2'b01;
      step();
      chk($sformatf("wrap_data%0d", k), 64'(bus.async_rd_data), 64'(k));
      chk($sformatf("wrap_valid%0d", k), 64'(bus.async_rd_valid), 64'h1);
    end
    bus.rt_valid_i = 2'b00;
    step();
    chk("wrap_empty", 64'(fill), 64'd0);

    // x0 write handling
    bus.async_rd_ready = 1'b0;
    put(0, '{addr: 5'd0, data: 32'h100});
    put(1, '{addr: 5'd7, data: 32'h107});
    bus.rt_valid_i = 2'b11;
    step();
    bus.rt_valid_i = 2'b00;
`ifdef RVV_XRF_WB_X0_FILTER_EN
    chk("x0_fill", 64'(fill), 64'd1);
    chk("x0_head", 64'(bus.async_rd_addr), 64'd7);
    chk("x0_data", 64'(bus.async_rd_data), 64'h107);
`else
    chk("x0_fill", 64'(fill), 64'd2);
    chk("x0_head0", 64'(bus.async_rd_addr), 64'd0);
    chk("x0_data0", 64'(bus.async_rd_data), 64'h100);
    bus.async_rd_ready = 1'b1;
    step();
    chk("x0_head1", 64'(bus.async_rd_addr), 64'd7);
`endif
    bus.async_rd_ready = 1'b1;
    step();
    step();
    chk("x0_empty", 64'(fill), 64'd0);

    // reset with 3 entries buffered
    bus.async_rd_ready = 1'b0;
    put(0, '{addr: 5'd13, data: 32'hD});
    put(1, '{addr: 5'd14, data: 32'hE});
    bus.rt_valid_i = 2'b11;
    step();
    put(0, '{addr: 5'd15, data: 32'hF});
    bus.rt_valid_i = 2'b01;
    step();
    bus.rt_valid_i = 2'b00;
    chk("pre_rst_fill", 64'(fill), 64'd3);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.async_rd_valid), 64'h0);
    chk("arst_fill", 64'(fill), 64'd0);
    step();
    rst = 1'b0;
    bus.async_rd_ready = 1'b1;
    step();
    chk("post_rst_ready", 64'(bus.rt_ready_o), 64'h3);
    chk("post_rst_valid0", 64'(bus.async_rd_valid), 64'h0);
    step();
    chk("post_rst_valid1", 64'(bus.async_rd_valid), 64'h0);
    chk("post_rst_fill", 64'(fill), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
